// File: rtl/protocol_pkg.sv
// Shared register-image types and readback framing helpers for the MCU link.
// synth_t is the packed register bank that is streamed back MSB first.
package protocol_pkg;

    localparam int N_OSCILLATORS = 4;

    typedef enum logic [7:0] {
        WAVE_SQUARE = 8'h00,
        WAVE_SAW    = 8'h01,
        WAVE_TRI    = 8'h02,
        WAVE_NOISE  = 8'h03,
        WAVE_SIN    = 8'h06
    } wave_shape_t;

    typedef struct packed {
        wave_shape_t shape;
        logic [15:0] freq;
    } osc_t;

    typedef struct packed {
        logic [31:0] balance;
    } pan_t;

    // 164 bits: the low nibble of the last byte on the wire is zero padding.
    typedef struct packed {
        logic [31:0]                master_volume;
        pan_t                       pan;
        osc_t [N_OSCILLATORS-1:0]   osc;
        logic [3:0]                 flags;
    } synth_t;

    localparam int SYNTH_T_BITS  = $bits(synth_t);
    localparam int SYNTH_T_BYTES = (SYNTH_T_BITS + 7) / 8;

    localparam logic [7:0] READBACK_SOF = 8'hA5;

    typedef enum logic [2:0] {
        RB_IDLE,
        RB_SOF,
        RB_PAYLOAD,
        RB_CSUM,
        RB_FIN
    } readback_state_t;

    function automatic logic [7:0] readback_csum_step(logic [7:0] acc, logic [7:0] b);
        return acc + b;
    endfunction

    function automatic synth_t reset_synth_t();
        synth_t s;
        s = '0;
        s.master_volume = 32'h0000_8000;
        for (int i = 0; i < N_OSCILLATORS; i++) begin
            s.osc[i].shape = WAVE_SIN;
        end
        return s;
    endfunction

endpackage

// File: rtl/synth_readback_tx_byte_stream_mux.sv
// Picks byte idx of a flat snapshot, byte 0 being the most significant.
// Out-of-range indices read as zero.
module byte_stream_mux #(
    parameter int N_BYTES = 1,
    parameter int IDX_W   = 1
) (
    input  logic [8*N_BYTES-1:0] data,
    input  logic [IDX_W-1:0]     idx,
    output logic [7:0]           byte_out
);

    always_comb begin
        byte_out = '0;
        if (int'(idx) < N_BYTES) begin
            byte_out = data[8*(N_BYTES-1-int'(idx)) +: 8];
        end
    end

endmodule

// File: rtl/synth_readback_tx.sv
// Streams a snapshot of the synth_t register image to the SPI slave as
// SOF, payload bytes MSB first, then an optional additive checksum.
module synth_readback_tx
    import protocol_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = READBACK_SOF,
    parameter bit         USE_CHECKSUM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  synth_t          synth_i,
    input  logic            start_i,
    input  logic            abort_i,
    output logic [7:0]      tx_data_o,
    output logic            tx_valid_o,
    input  logic            tx_ready_i,
    output logic            busy_o,
    output logic            done_o,
    output readback_state_t dbg_state
);

    localparam int PAYLOAD_BITS = $bits(synth_t);
    localparam int N_BYTES      = (PAYLOAD_BITS + 7) / 8;
    localparam int CW           = $clog2(N_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);

    readback_state_t      state;
    logic [8*N_BYTES-1:0] snap_q;
    logic [8*N_BYTES-1:0] snap_d;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        mux_idx;
    logic [7:0]           csum;
    logic [7:0]           csum_next;
    logic [7:0]           next_byte;
    logic                 xfer;

    // Handshake: a byte moves on any cycle with tx_valid_o && tx_ready_i;
    // once raised, tx_valid_o/tx_data_o hold until that cycle (or abort/rst).
    assign xfer      = tx_valid_o && tx_ready_i;
    assign csum_next = readback_csum_step(csum, tx_data_o);
    assign dbg_state = state;

    // Look one byte ahead so tx_data_o can be loaded on the transfer edge.
    assign mux_idx = (state == RB_PAYLOAD) ? cnt + CW'(1) : '0;

    always_comb begin
        snap_d = '0;
        snap_d[8*N_BYTES-1 -: PAYLOAD_BITS] = synth_i;
    end

    byte_stream_mux #(
        .N_BYTES (N_BYTES),
        .IDX_W   (CW)
    ) u_mux (
        .data     (snap_q),
        .idx      (mux_idx),
        .byte_out (next_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RB_IDLE;
            snap_q     <= '0;
            cnt        <= '0;
            csum       <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else if (abort_i && state != RB_IDLE) begin
            state      <= RB_IDLE;
            cnt        <= '0;
            csum       <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                RB_IDLE: begin
                    if (start_i) begin
                        snap_q     <= snap_d;
                        cnt        <= '0;
                        csum       <= '0;
                        tx_data_o  <= SOF_BYTE;
                        tx_valid_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= RB_SOF;
                    end
                end
                RB_SOF: begin
                    if (xfer) begin
                        tx_data_o <= next_byte;
                        state     <= RB_PAYLOAD;
                    end
                end
                RB_PAYLOAD: begin
                    if (xfer) begin
                        csum <= csum_next;
                        if (cnt == LAST_IDX) begin
                            if (USE_CHECKSUM) begin
                                tx_data_o <= csum_next;
                                state     <= RB_CSUM;
                            end else begin
                                tx_data_o  <= '0;
                                tx_valid_o <= 1'b0;
                                done_o     <= 1'b1;
                                state      <= RB_FIN;
                            end
                        end else begin
                            cnt       <= cnt + CW'(1);
                            tx_data_o <= next_byte;
                        end
                    end
                end
                RB_CSUM: begin
                    if (xfer) begin
                        tx_data_o  <= '0;
                        tx_valid_o <= 1'b0;
                        done_o     <= 1'b1;
                        state      <= RB_FIN;
                    end
                end
                RB_FIN: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                    state  <= RB_IDLE;
                end
                default: state <= RB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synth_readback_tx.sv
// Bench for synth_readback_tx: randomized images and backpressure checked
// against a frame model built directly from the packed image.
module tb_synth_readback_tx;
    import protocol_pkg::*;

    localparam int PAYLOAD_BITS = $bits(synth_t);
    localparam int N_BYTES      = (PAYLOAD_BITS + 7) / 8;
    localparam int BUDGET       = 2000;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    synth_t          synth;
    logic            start, abort, tx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid, busy, done;
    readback_state_t st;

    logic            start1, abort1, ready1;
    logic [7:0]      tx_data1;
    logic            tx_valid1, busy1, done1;
    readback_state_t st1;

    synth_readback_tx #(.SOF_BYTE(8'hA5), .USE_CHECKSUM(1'b1)) dut (
        .clk(clk), .rst(rst), .synth_i(synth), .start_i(start), .abort_i(abort),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .done_o(done), .dbg_state(st)
    );

    synth_readback_tx #(.SOF_BYTE(8'hA5), .USE_CHECKSUM(1'b0)) dut_nocs (
        .clk(clk), .rst(rst), .synth_i(synth), .start_i(start1), .abort_i(abort1),
        .tx_data_o(tx_data1), .tx_valid_o(tx_valid1), .tx_ready_i(ready1),
        .busy_o(busy1), .done_o(done1), .dbg_state(st1)
    );

    assert property (@(posedge clk) disable iff (rst)
        (tx_valid && !tx_ready && !abort) |=> (tx_valid && $stable(tx_data)));

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] prev_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic synth_t rand_image();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[32*i +: 32] = $urandom();
        return synth_t'(r[PAYLOAD_BITS-1:0]);
    endfunction

    // Reference frame: the image, left-justified in N_BYTES bytes, sliced
    // MSB first by shifting; the checksum is the plain byte sum mod 256.
    task automatic build_expected(input synth_t img, input bit use_cs);
        logic [8*N_BYTES-1:0] flat;
        int sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        flat = (8*N_BYTES)'(img) << (8*N_BYTES - PAYLOAD_BITS);
        sum = 0;
        for (int k = 0; k < N_BYTES; k++) begin
            logic [7:0] b;
            b = 8'(flat >> (8 * (N_BYTES - 1 - k)));
            exp_q.push_back(b);
            sum += int'(b);
        end
        if (use_cs) exp_q.push_back(8'(sum % 256));
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(tx_valid), 32'(0));
        check({tag, "_busy"},  32'(busy),     32'(0));
        check({tag, "_done"},  32'(done),     32'(0));
    endtask

    // driver: one frame on the checksum instance, ready at pct% duty
    task automatic run_frame(input int pct, input bit poke_balance, input bit mid_start,
                             output int done_cycle);
        int         cyc;
        bit         prev_hold;
        logic [7:0] prev_data;
        build_expected(synth, 1'b1);
        got_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        prev_hold  = 1'b0;
        prev_data  = '0;
        done_cycle = -1;
        check("start_busy", 32'(busy), 32'(1));
        check("start_sof",  32'({tx_valid, tx_data}), 32'({1'b1, 8'hA5}));
        while (cyc < BUDGET) begin
            if (prev_hold) begin
                check("hold_valid", 32'(tx_valid), 32'(1));
                check("hold_data",  32'(tx_data),  32'(prev_data));
            end
            if (done) begin
                done_cycle = cyc;
                break;
            end
            tx_ready = ($urandom_range(99) < pct);
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            start = (mid_start && cyc == 6);
            if (poke_balance && cyc == 1) synth.pan.balance = 32'hDEADBEEF;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 32'(done_cycle > 0), 32'(1));
        @(negedge clk);
        check_idle("after_done");
    endtask

    // driver: one frame on the no-checksum instance, ready held high
    task automatic run_frame_nocs(output int done_cycle);
        int cyc;
        build_expected(synth, 1'b0);
        got_q.delete();
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 1;
        done_cycle = -1;
        while (cyc < BUDGET) begin
            if (done1) begin
                done_cycle = cyc;
                break;
            end
            if (tx_valid1) got_q.push_back(tx_data1);
            @(negedge clk);
            cyc++;
        end
        check("nocs_done_cycle", 32'(done_cycle), 32'(N_BYTES + 2));
        compare_frame("nocs");
        @(negedge clk);
        check("nocs_idle", 32'({tx_valid1, busy1, done1}), 32'(0));
    endtask

    initial begin
        int  dc;
        bit  seen;
        synth_t img;

        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        synth = rand_image();
        repeat (3) @(negedge clk);
        check("rst_data",  32'(tx_data),  32'(0));
        check_idle("rst");
        check("rst_nocs",  32'({tx_data1, tx_valid1, busy1, done1}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // reset image, full-rate transfer
        img = reset_synth_t();
        img.master_volume = 32'h01020304;
        synth = img;
        run_frame(100, 1'b0, 1'b0, dc);
        check("full_done_cycle", 32'(dc), 32'(N_BYTES + 3));
        compare_frame("full");
        check("full_csum_const", 32'(got_q[got_q.size()-1]), 32'(8'(8'h0A + 6 * N_OSCILLATORS)));
        prev_q = got_q;

        // same image under 30% backpressure gives the same stream
        run_frame(30, 1'b0, 1'b0, dc);
        compare_frame("bp");
        check("bp_same_len", 32'(got_q.size()), 32'(prev_q.size()));
        for (int i = 0; i < prev_q.size() && i < got_q.size(); i++)
            check($sformatf("bp_same%0d", i), 32'(got_q[i]), 32'(prev_q[i]));

        // snapshot isolation and ignored mid-frame start
        synth = rand_image();
        run_frame(100, 1'b1, 1'b1, dc);
        compare_frame("snap");
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (tx_valid || busy || done) seen = 1'b1;
        end
        check("no_second_frame", 32'(seen), 32'(0));

        // abort while payload byte 5 is offered, with ready high
        synth = rand_image();
        build_expected(synth, 1'b1);
        tx_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_at_byte5", 32'({tx_valid, tx_data}), 32'({1'b1, exp_q[6]}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        seen = 1'b0;
        repeat (N_BYTES + 4) begin
            @(negedge clk);
            if (done || tx_valid) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'(0));
        synth = rand_image();
        run_frame(100, 1'b0, 1'b0, dc);
        check("post_abort_done_cycle", 32'(dc), 32'(N_BYTES + 3));
        compare_frame("post_abort");

        // random images, mixed backpressure
        for (int t = 0; t < 4; t++) begin
            synth = rand_image();
            run_frame(($urandom_range(1) == 0) ? 30 : 100, 1'b0, 1'b0, dc);
            compare_frame($sformatf("rand%0d", t));
        end

        // checksum-less build
        for (int t = 0; t < 2; t++) begin
            synth = rand_image();
            run_frame_nocs(dc);
        end

        // reset mid-frame drops the frame without done
        tx_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_rst");
        seen = 1'b0;
        repeat (N_BYTES + 4) begin
            @(negedge clk);
            if (done || tx_valid) seen = 1'b1;
        end
        check("mid_rst_quiet", 32'(seen), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
